// File: rtl/dadda_mac_sequencer_if.sv
// rtl/dadda_mac_sequencer_if.sv - operand/result handshake bundle for dadda_mac_sequencer
//
// Purpose: groups the operand input stream and the result output port.
// Ports:
//   in_valid/in_ready         operand pair handshake
//   in_a, in_b                8-bit multiplicand / multiplier
//   in_init                   16-bit accumulator seed (first term only)
//   in_last                   final term of a packet
//   out_valid/out_ready       result handshake
//   out_sum, out_carry        16-bit dot product, sticky carry
//   out_terms                 saturating term count (CNT_W bits)
// Modports: master = operand source / result sink, slave = sequencer.
interface dadda_mac_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [15:0]      in_init;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] out_terms;

  modport master (
    output in_valid, in_a, in_b, in_init, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_terms
  );

  modport slave (
    input  in_valid, in_a, in_b, in_init, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_terms
  );
endinterface

// File: rtl/dadda_mac_sequencer.sv
// rtl/dadda_mac_sequencer.sv - sequential multiply-accumulate front-end over 8-bit operand pairs
//
// Purpose: accepts one operand pair per 3 cycles, forms a*b + acc as two
// carry-save rows (MUL), resolves them into the 16-bit accumulator (ADD), and
// presents the packet result with a sticky carry and term count (OUT).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dadda_mac_sequencer_if.slave (operand stream in, result out)
// Parameter: CNT_W - width of the saturating term counter.
// Optional feature: define DADDA_MAC_SATURATE_EN to clamp the accumulator at
// 16'hFFFF on overflow instead of wrapping.
module dadda_mac_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dadda_mac_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {ACCEPT, MUL, ADD, OUT} state_t;

  state_t           state_q;
  logic [7:0]       op_a_q;
  logic [7:0]       op_b_q;
  logic             last_q;
  logic [15:0]      seed_q;
  logic [16:0]      row0_q;
  logic [16:0]      row1_q;
  logic [15:0]      acc_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q;

  logic [15:0] prod;
  logic [16:0] row0;
  logic [16:0] row1;
  logic [16:0] result;

  // Multiply tree stage: product plus accumulator kept as a sum row and a
  // shifted carry row, so no carry propagates in the MUL cycle.
  assign prod   = {8'd0, op_a_q} * {8'd0, op_b_q};
  assign row0   = {1'b0, prod ^ seed_q};
  assign row1   = {prod & seed_q, 1'b0};
  // Both rows stay below 2^17 combined, so bit 16 is the true carry-out.
  assign result = row0_q + row1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      op_a_q  <= '0;
      op_b_q  <= '0;
      last_q  <= 1'b0;
      seed_q  <= '0;
      row0_q  <= '0;
      row1_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (bus.in_valid) begin
            op_a_q  <= bus.in_a;
            op_b_q  <= bus.in_b;
            last_q  <= bus.in_last;
            // Seed only comes from the input on the first term of a packet.
            seed_q  <= first_q ? bus.in_init : acc_q;
            state_q <= MUL;
          end
        end
        MUL: begin
          row0_q  <= row0;
          row1_q  <= row1;
          state_q <= ADD;
        end
        ADD: begin
`ifdef DADDA_MAC_SATURATE_EN
          acc_q   <= result[16] ? 16'hFFFF : result[15:0];
`else
          acc_q   <= result[15:0];
`endif
          carry_q <= carry_q | result[16];
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          first_q <= 1'b0;
          state_q <= last_q ? OUT : ACCEPT;
        end
        OUT: begin
          if (bus.out_ready) begin
            first_q <= 1'b1;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ACCEPT;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  // Handshake outputs decode the state register only; data outputs are registers.
  assign bus.in_ready  = (state_q == ACCEPT);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = carry_q;
  assign bus.out_terms = cnt_q;

endmodule

// File: tb/tb_dadda_mac_sequencer.sv
// tb/tb_dadda_mac_sequencer.sv - self-checking bench for dadda_mac_sequencer
module tb_dadda_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef DADDA_MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dadda_mac_sequencer_if #(.CNT_W(8)) bus ();
  dadda_mac_sequencer_if #(.CNT_W(2)) bus2 ();

  dadda_mac_sequencer #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  dadda_mac_sequencer #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    int                n;
    logic [3:0][7:0]   a;
    logic [3:0][7:0]   b;
    logic [3:0][15:0]  init;
    logic [15:0]       sum;
    logic [15:0]       sum_sat;
    logic              carry;
    logic [7:0]        terms;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] init, input logic [15:0] s,
                              input logic [15:0] ss, input logic c, input logic [7:0] t);
    vec_t v;
    v.n = n; v.a = a; v.b = b; v.init = init;
    v.sum = s; v.sum_sat = ss; v.carry = c; v.terms = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves in_valid high and returns at the negedge after the accept edge.
  task automatic send_term(input logic [7:0] a, input logic [7:0] b, input logic [15:0] init,
                           input logic last, output int acc_cyc);
    int k;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_init  = init;
    bus.in_last  = last;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  // Called at the negedge right after the last term's accept edge.
  task automatic finish_packet(input string tag, input logic [15:0] s, input logic c,
                               input logic [7:0] t);
    int k;
    @(negedge clk);
    check({tag, "_ov_low_in_add"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_ov_rise"}, 32'(bus.out_valid), 32'd1);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_sum"}, 32'(bus.out_sum), 32'(s));
    check({tag, "_carry"}, 32'(bus.out_carry), 32'(c));
    check({tag, "_terms"}, 32'(bus.out_terms), 32'(t));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ov_fall"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_packet(input vec_t v, input string tag);
    int prev;
    int c;
    prev = 0;
    for (int i = 0; i < v.n; i++) begin
      send_term(v.a[i], v.b[i], v.init[i], (i == v.n - 1), c);
      if (i > 0) check({tag, "_spacing"}, 32'(c - prev), 32'd3);
      prev = c;
    end
    bus.in_valid = 1'b0;
    finish_packet(tag, SAT ? v.sum_sat : v.sum, v.carry, v.terms);
  endtask

  initial begin
    int c;
    int k;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_init = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_init = '0;
    bus2.in_last = 1'b0; bus2.out_ready = 1'b0;

    vecs[0] = mk(1, 32'h0000_00ff, 32'h0000_00ff, 64'h0000_0000_0000_0f0f,
                 16'h0D10, 16'hFFFF, 1'b1, 8'd1);
    vecs[1] = mk(2, 32'h0000_bbaa, 32'h0000_ff01, 64'h0000_0000_1234_f111,
                 16'hAC00, 16'hFFFF, 1'b1, 8'd2);
    vecs[2] = mk(4, 32'h2323_2323, 32'h1d1d_1d1d, 64'h2222_2222_2222_2222,
                 16'h31FE, 16'h31FE, 1'b0, 8'd4);
    vecs[3] = mk(1, 32'h0000_0080, 32'h0000_0002, 64'h0000_0000_0000_7f00,
                 16'h8000, 16'h8000, 1'b0, 8'd1);
    vecs[4] = mk(3, 32'h0001_00ff, 32'h0005_0001, 64'h0000_5555_aaaa_ff01,
                 16'h0005, 16'hFFFF, 1'b1, 8'd3);

    // Reset state
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("rst_out_terms", 32'(bus.out_terms), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven packets
    for (int i = 0; i < 5; i++) run_packet(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while a new term waits at the input
    send_term(8'hff, 8'hff, 16'h0f0f, 1'b1, c);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp_ov", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1; bus.in_a = 8'h02; bus.in_b = 8'h03;
    bus.in_init = 16'h0001; bus.in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_ov", 32'(bus.out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_sum", 32'(bus.out_sum), SAT ? 32'h0000FFFF : 32'h00000D10);
      check("bp_hold_carry", 32'(bus.out_carry), 32'd1);
      check("bp_hold_terms", 32'(bus.out_terms), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_ov", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_held_term_taken", 32'(bus.in_ready), 32'd0);
    check("bp_single_transfer", 32'(bus.out_valid), 32'd0);
    finish_packet("bp_next", 16'h0007, 1'b0, 8'd1);

    // Reset during ADD of the second term
    send_term(8'haa, 8'h01, 16'hf111, 1'b0, c);
    send_term(8'hbb, 8'hff, 16'h1234, 1'b0, c);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("mid_rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("mid_rst_out_terms", 32'(bus.out_terms), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_packet(mk(1, 32'h0000_0030, 32'h0000_0054, 64'h0000_0000_0000_c501,
                  16'hD4C1, 16'hD4C1, 1'b0, 8'd1), "post_rst");

    // Term count saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_a = 8'h01; bus2.in_b = 8'h01;
      bus2.in_init = 16'h0000; bus2.in_last = (i == 4);
      k = 0;
      while (!bus2.in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!bus2.in_ready) check("sat_in_ready_timeout", 32'(bus2.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    k = 0;
    while (!bus2.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("sat_ov", 32'(bus2.out_valid), 32'd1);
    check("sat_terms", 32'(bus2.out_terms), 32'd3);
    check("sat_sum", 32'(bus2.out_sum), 32'h0005);
    check("sat_carry", 32'(bus2.out_carry), 32'd0);
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
    check("sat_ov_fall", 32'(bus2.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
